// File: rtl/cpu_ctrl_fsm_if.sv
// Memory-side handshake between the CPU control FSM and the memory port.
// The FSM owns the request, write enable and address select; memory returns ack.
interface cpu_ctrl_fsm_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ack
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/memory/write-back/branch/halt
// sequencing with a retired-instruction counter.
module cpu_ctrl_fsm (
    input  logic                  clk,
    input  logic                  reset,
    cpu_ctrl_fsm_if.master        mem,
    input  logic [4:0]            opcode,
    input  logic [1:0]            flag,
    output logic                  ir_write,
    output logic                  alu_src,
    output logic                  reg_write,
    output logic                  wb_sel,
    output logic                  pc_write,
    output logic                  pc_src,
    output logic                  illegal,
    output logic                  halted,
    output logic [2:0]            state,
    output logic [31:0]           instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_HALT   = 3'd6,
        S_SPARE  = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        C_ALU_REG = 4'd0,
        C_ALU_IMM = 4'd1,
        C_LOAD    = 4'd2,
        C_STORE   = 4'd3,
        C_JMP     = 4'd4,
        C_BEQ     = 4'd5,
        C_BL      = 4'd6,
        C_BG      = 4'd7,
        C_HALT    = 4'd8,
        C_UNDEF   = 4'd9
    } op_class_e;

    function automatic op_class_e op_class(input logic [4:0] op);
        op_class_e cls;
        casez (op)
            5'b00???: cls = C_ALU_REG;
            5'b01???: cls = C_ALU_IMM;
            5'b10000: cls = C_LOAD;
            5'b10001: cls = C_STORE;
            5'b11000: cls = C_JMP;
            5'b11001: cls = C_BEQ;
            5'b11010: cls = C_BL;
            5'b11011: cls = C_BG;
            5'b11111: cls = C_HALT;
            default:  cls = C_UNDEF;
        endcase
        return cls;
    endfunction

    state_e      state_r;
    state_e      next_state_s;
    logic [4:0]  op_r;
    logic [31:0] instr_cnt_r;
    op_class_e   dec_cls_s;
    op_class_e   op_cls_s;
    logic        taken_s;

    logic mem_req_s;
    logic mem_we_s;
    logic addr_sel_s;
    logic ir_write_s;
    logic alu_src_s;
    logic reg_write_s;
    logic wb_sel_s;
    logic pc_write_s;
    logic pc_src_s;
    logic illegal_s;
    logic halted_s;

    // DECODE classifies the live opcode; later states only see the registered copy.
    assign dec_cls_s = op_class(opcode);
    assign op_cls_s  = op_class(op_r);
    assign taken_s   = (op_cls_s == C_JMP)
                     | ((op_cls_s == C_BEQ) & (flag == 2'b01))
                     | ((op_cls_s == C_BL)  & (flag == 2'b10))
                     | ((op_cls_s == C_BG)  & (flag == 2'b11));

    // Next-state and per-state control strobes.
    always_comb begin
        next_state_s = state_r;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        addr_sel_s   = 1'b0;
        ir_write_s   = 1'b0;
        alu_src_s    = 1'b0;
        reg_write_s  = 1'b0;
        wb_sel_s     = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = 1'b0;
        illegal_s    = 1'b0;
        halted_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req_s  = 1'b1;
                ir_write_s = mem.mem_ack;
                if (mem.mem_ack) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (dec_cls_s)
                    C_ALU_REG, C_ALU_IMM, C_LOAD, C_STORE: next_state_s = S_EXEC;
                    C_JMP, C_BEQ, C_BL, C_BG:              next_state_s = S_BRANCH;
                    C_HALT:                                next_state_s = S_HALT;
                    default: begin
                        illegal_s    = 1'b1;
                        pc_write_s   = 1'b1;
                        next_state_s = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                alu_src_s = (op_cls_s != C_ALU_REG);
                if ((op_cls_s == C_LOAD) || (op_cls_s == C_STORE)) begin
                    next_state_s = S_MEM;
                end else begin
                    next_state_s = S_WB;
                end
            end
            S_MEM: begin
                mem_req_s  = 1'b1;
                addr_sel_s = 1'b1;
                mem_we_s   = (op_cls_s == C_STORE);
                if (mem.mem_ack) begin
                    if (op_cls_s == C_STORE) begin
                        pc_write_s   = 1'b1;
                        next_state_s = S_FETCH;
                    end else begin
                        next_state_s = S_WB;
                    end
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB: begin
                reg_write_s  = 1'b1;
                wb_sel_s     = (op_cls_s == C_LOAD);
                pc_write_s   = 1'b1;
                next_state_s = S_FETCH;
            end
            S_BRANCH: begin
                pc_write_s   = 1'b1;
                pc_src_s     = taken_s;
                next_state_s = S_FETCH;
            end
            S_HALT: begin
                halted_s     = 1'b1;
                next_state_s = S_HALT;
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

    // State, captured opcode and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_FETCH;
            op_r        <= 5'd0;
            instr_cnt_r <= 32'd0;
        end else begin
            state_r <= next_state_s;
            if (state_r == S_DECODE) begin
                op_r <= opcode;
            end
            if (pc_write_s) begin
                instr_cnt_r <= instr_cnt_r + 32'd1;
            end
        end
    end

    // Reset blanks every strobe so an in-flight memory request is dropped at once.
    assign mem.mem_req  = mem_req_s   & ~reset;
    assign mem.mem_we   = mem_we_s    & ~reset;
    assign mem.addr_sel = addr_sel_s  & ~reset;
    assign ir_write     = ir_write_s  & ~reset;
    assign alu_src      = alu_src_s   & ~reset;
    assign reg_write    = reg_write_s & ~reset;
    assign wb_sel       = wb_sel_s    & ~reset;
    assign pc_write     = pc_write_s  & ~reset;
    assign pc_src       = pc_src_s    & ~reset;
    assign illegal      = illegal_s   & ~reset;
    assign halted       = halted_s    & ~reset;
    assign state        = state_r;
    assign instr_cnt    = instr_cnt_r;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: an instruction-level model expands each
// instruction into its expected per-cycle trace, which is compared against the DUT.
module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  opcode;
    logic [1:0]  flag;
    logic        ir_write, alu_src, reg_write, wb_sel, pc_write, pc_src, illegal, halted;
    logic [2:0]  state;
    logic [31:0] instr_cnt;

    cpu_ctrl_fsm_if bus ();

    cpu_ctrl_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .mem       (bus),
        .opcode    (opcode),
        .flag      (flag),
        .ir_write  (ir_write),
        .alu_src   (alu_src),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .illegal   (illegal),
        .halted    (halted),
        .state     (state),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_cnt;

    // Per-cycle expected vector, stimulus and counter value; observed captures.
    logic [13:0] exp_q[$];
    logic [7:0]  stim_q[$];
    logic [31:0] cnt_q[$];
    logic [13:0] obs_q[$];
    logic [31:0] ocnt_q[$];

    // Packing: state, mem_req, mem_we, addr_sel, ir_write, alu_src, reg_write,
    // wb_sel, pc_write, pc_src, illegal, halted.
    function automatic logic [13:0] ev(input logic [2:0] st, input logic req, we, as, ir, alu,
                                       rw, wb, pw, ps, il, h);
        return {st, req, we, as, ir, alu, rw, wb, pw, ps, il, h};
    endfunction

    function automatic logic [13:0] obs();
        return {state, bus.mem_req, bus.mem_we, bus.addr_sel, ir_write, alu_src,
                reg_write, wb_sel, pc_write, pc_src, illegal, halted};
    endfunction

    function automatic logic [4:0] rop();
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic logic [1:0] rfl();
        return 2'($urandom_range(0, 3));
    endfunction

    function automatic logic rack();
        return 1'($urandom_range(0, 1));
    endfunction

    // 0 alu-reg, 1 alu-imm, 2 load, 3 store, 4 jmp, 5 beq, 6 bl, 7 bg, 8 halt, 9 undefined
    function automatic int cls_of(input logic [4:0] op);
        int v;
        v = int'(op);
        if (v < 8)        return 0;
        else if (v < 16)  return 1;
        else if (v == 16) return 2;
        else if (v == 17) return 3;
        else if (v >= 24 && v <= 27) return v - 20;
        else if (v == 31) return 8;
        else              return 9;
    endfunction

    task automatic push(input logic [13:0] e, input logic [4:0] op, input logic [1:0] fl,
                        input logic ack);
        exp_q.push_back(e);
        stim_q.push_back({op, fl, ack});
        cnt_q.push_back(m_cnt);
        if (e[3]) m_cnt = m_cnt + 32'd1;
    endtask

    // Expand one instruction into its expected cycle-by-cycle trace.
    task automatic model_instr(input logic [4:0] op, input logic [1:0] fl, input int fw,
                               input int mw);
        int   cls;
        logic tk;
        logic st;
        cls = cls_of(op);
        for (int i = 0; i < fw; i++) push(ev(3'd0,1,0,0,0,0,0,0,0,0,0,0), rop(), rfl(), 1'b0);
        push(ev(3'd0,1,0,0,1,0,0,0,0,0,0,0), rop(), rfl(), 1'b1);
        if (cls == 9) begin
            push(ev(3'd1,0,0,0,0,0,0,0,1,0,1,0), op, rfl(), rack());
            return;
        end
        push(ev(3'd1,0,0,0,0,0,0,0,0,0,0,0), op, rfl(), rack());
        if (cls >= 4 && cls <= 7) begin
            tk = (cls == 4) || (cls == 5 && fl == 2'b01) || (cls == 6 && fl == 2'b10)
                 || (cls == 7 && fl == 2'b11);
            push(ev(3'd5,0,0,0,0,0,0,0,1,tk,0,0), rop(), fl, rack());
            return;
        end
        if (cls == 8) begin
            for (int i = 0; i < 6; i++) push(ev(3'd6,0,0,0,0,0,0,0,0,0,0,1), rop(), rfl(), rack());
            return;
        end
        push(ev(3'd2,0,0,0,0,(cls != 0),0,0,0,0,0,0), rop(), rfl(), rack());
        if (cls == 2 || cls == 3) begin
            st = (cls == 3);
            for (int i = 0; i < mw; i++) push(ev(3'd3,1,st,1,0,0,0,0,0,0,0,0), rop(), rfl(), 1'b0);
            push(ev(3'd3,1,st,1,0,0,0,0,st,0,0,0), rop(), rfl(), 1'b1);
            if (st) return;
        end
        push(ev(3'd4,0,0,0,0,0,1,(cls == 2),1,0,0,0), rop(), rfl(), rack());
    endtask

    task automatic clear_q();
        exp_q.delete(); stim_q.delete(); cnt_q.delete(); obs_q.delete(); ocnt_q.delete();
    endtask

    // Apply the first n stimulus entries, capturing outputs mid-cycle.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n && i < stim_q.size(); i++) begin
            {opcode, flag, bus.mem_ack} = stim_q[i];
            @(negedge clk);
            obs_q.push_back(obs());
            ocnt_q.push_back(instr_cnt);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            {opcode, flag, bus.mem_ack} = {rop(), rfl(), rack()};
            @(negedge clk);
            total++;
            if (obs() !== 14'd0 || instr_cnt !== 32'd0) begin
                bad++;
                $display("FAIL reset[%0d]: got %h/%0d want %h/0", i, obs(), instr_cnt, 14'd0);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_cnt = 32'd0;
    endtask

    task automatic test_alu_imm();
        clear_q();
        model_instr(5'b01000, rfl(), 0, 0);
        run_cycles(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i] || ocnt_q[i] !== cnt_q[i]) begin
                bad++;
                $display("FAIL alu_imm cyc %0d: got %h/%0d want %h/%0d", i, obs_q[i], ocnt_q[i], exp_q[i], cnt_q[i]);
            end
        end
    endtask

    task automatic test_load_delay();
        clear_q();
        model_instr(5'b10000, rfl(), 0, 2);
        model_instr(5'b10001, rfl(), 1, 1);
        run_cycles(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i] || ocnt_q[i] !== cnt_q[i]) begin
                bad++;
                $display("FAIL load_store cyc %0d: got %h/%0d want %h/%0d", i, obs_q[i], ocnt_q[i], exp_q[i], cnt_q[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [6:0] cases [8] = '{{5'b11001, 2'b01}, {5'b11001, 2'b00}, {5'b11000, 2'b00},
                                  {5'b11000, 2'b10}, {5'b11010, 2'b10}, {5'b11010, 2'b01},
                                  {5'b11011, 2'b11}, {5'b11011, 2'b10}};
        clear_q();
        for (int c = 0; c < 8; c++) model_instr(cases[c][6:2], cases[c][1:0], $urandom_range(0, 2), 0);
        run_cycles(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i] || ocnt_q[i] !== cnt_q[i]) begin
                bad++;
                $display("FAIL branch cyc %0d: got %h/%0d want %h/%0d", i, obs_q[i], ocnt_q[i], exp_q[i], cnt_q[i]);
            end
        end
    endtask

    task automatic test_illegal();
        clear_q();
        model_instr(5'b10101, rfl(), 0, 0);
        model_instr(5'b10010, rfl(), 1, 0);
        model_instr(5'b11100, rfl(), 0, 0);
        run_cycles(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i] || ocnt_q[i] !== cnt_q[i]) begin
                bad++;
                $display("FAIL illegal cyc %0d: got %h/%0d want %h/%0d", i, obs_q[i], ocnt_q[i], exp_q[i], cnt_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] op;
        clear_q();
        for (int k = 0; k < 60; k++) begin
            op = rop();
            if (op == 5'd31) op = 5'd30;
            model_instr(op, rfl(), $urandom_range(0, 2), $urandom_range(0, 3));
        end
        run_cycles(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i] || ocnt_q[i] !== cnt_q[i]) begin
                bad++;
                $display("FAIL back_to_back cyc %0d: got %h/%0d want %h/%0d", i, obs_q[i], ocnt_q[i], exp_q[i], cnt_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        clear_q();
        model_instr(5'b10001, rfl(), 0, 5);
        run_cycles(5);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i] || ocnt_q[i] !== cnt_q[i]) begin
                bad++;
                $display("FAIL mid_mem cyc %0d: got %h/%0d want %h/%0d", i, obs_q[i], ocnt_q[i], exp_q[i], cnt_q[i]);
            end
        end
        reset = 1'b1;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        total++;
        if (obs() !== ev(3'd3,0,0,0,0,0,0,0,0,0,0,0)) begin
            bad++;
            $display("FAIL mid_mem_in_reset: got %h want %h", obs(), ev(3'd3,0,0,0,0,0,0,0,0,0,0,0));
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.mem_ack = 1'b0;
        m_cnt = 32'd0;
        @(negedge clk);
        total++;
        if (obs() !== ev(3'd0,1,0,0,0,0,0,0,0,0,0,0) || instr_cnt !== 32'd0) begin
            bad++;
            $display("FAIL mid_mem_after_reset: got %h/%0d want %h/0", obs(), instr_cnt, ev(3'd0,1,0,0,0,0,0,0,0,0,0,0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_halt();
        clear_q();
        model_instr(5'b01011, rfl(), 0, 0);
        model_instr(5'b11111, rfl(), 1, 0);
        run_cycles(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i] || ocnt_q[i] !== cnt_q[i]) begin
                bad++;
                $display("FAIL halt cyc %0d: got %h/%0d want %h/%0d", i, obs_q[i], ocnt_q[i], exp_q[i], cnt_q[i]);
            end
        end
        reset = 1'b1;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        total++;
        if (obs() !== ev(3'd6,0,0,0,0,0,0,0,0,0,0,0)) begin
            bad++;
            $display("FAIL halt_in_reset: got %h want %h", obs(), ev(3'd6,0,0,0,0,0,0,0,0,0,0,0));
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.mem_ack = 1'b0;
        m_cnt = 32'd0;
        @(negedge clk);
        total++;
        if (obs() !== ev(3'd0,1,0,0,0,0,0,0,0,0,0,0) || instr_cnt !== 32'd0) begin
            bad++;
            $display("FAIL halt_after_reset: got %h/%0d want %h/0", obs(), instr_cnt, ev(3'd0,1,0,0,0,0,0,0,0,0,0,0));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset       = 1'b1;
        opcode      = 5'd0;
        flag        = 2'd0;
        bus.mem_ack = 1'b0;
        m_cnt       = 32'd0;
        test_reset();
        test_alu_imm();
        test_load_delay();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_reset_mid_mem();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high; sampled on rising clk edge.
REQ-003 SHALL have ports: opcode  in  5  instruction opcode from IR; valid from DECODE onward.
REQ-004 SHALL have ports: flag  in  2  compare flags: 01 equal, 10 less, 11 greater, 00 none.
REQ-005 SHALL have ports: mem_ack  in  1  memory completes current request this cycle.
REQ-006 SHALL have ports: mem_req  out  1  memory request, held until mem_ack.
REQ-007 SHALL have ports: mem_we  out  1  memory write enable, valid only with mem_req.
REQ-008 SHALL have ports: addr_sel  out  1  address source: 0 PC, 1 ALU result.
REQ-009 SHALL have ports: ir_write  out  1  one-cycle IR load strobe.
REQ-010 SHALL have ports: alu_src  out  1  ALU operand B: 0 register, 1 imm_ext.
REQ-011 SHALL have ports: reg_write  out  1  register-file write strobe.
REQ-012 SHALL have ports: wb_sel  out  1  write-back source: 0 ALU, 1 memory data.
REQ-013 SHALL have ports: pc_write  out  1  one-cycle PC update strobe.
REQ-014 SHALL have ports: pc_src  out  1  PC source: 0 PC+4, 1 branch_target.
REQ-015 SHALL have ports: illegal  out  1  one-cycle pulse on undefined opcode.
REQ-016 SHALL have ports: halted  out  1  high while in HALT.
REQ-017 SHALL have ports: state  out  3  current state encoding.
REQ-018 SHALL have ports: instr_cnt  out  32  retired-instruction counter.

Function
REQ-019 SHALL encode states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, HALT=6; 7 unreachable, maps to FETCH next cycle.
REQ-020 SHALL decode opcode classes: 00xxx ALU-reg; 01xxx ALU-imm; 10000 LOAD; 10001 STORE; 11000 JMP; 11001 BEQ; 11010 BL; 11011 BG; 11111 HALT; all others undefined.
REQ-021 SHALL register opcode into an internal op register in DECODE; EXEC/MEM/WB/BRANCH use only the registered value.
REQ-022 FETCH: mem_req=1, mem_we=0, addr_sel=0; ir_write=mem_ack; stay while mem_ack=0; on mem_ack -> DECODE.
REQ-023 DECODE (1 cycle): ALU/LOAD/STORE -> EXEC; JMP/BEQ/BL/BG -> BRANCH; HALT -> HALT; undefined -> FETCH with illegal=1, pc_write=1, pc_src=0.
REQ-024 EXEC (1 cycle): alu_src=1 for ALU-imm/LOAD/STORE, 0 for ALU-reg; ALU -> WB; LOAD/STORE -> MEM.
REQ-025 MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE only; hold until mem_ack; on ack LOAD -> WB, STORE -> FETCH with pc_write=1, pc_src=0.
REQ-026 WB (1 cycle): reg_write=1, wb_sel=1 for LOAD else 0, pc_write=1, pc_src=0; -> FETCH.
REQ-027 BRANCH (1 cycle): taken = JMP | (BEQ & flag==01) | (BL & flag==10) | (BG & flag==11); pc_write=1, pc_src=taken; -> FETCH.
REQ-028 HALT: all strobes 0, halted=1; exit only by reset; mem_ack ignored.
REQ-029 Outputs SHALL be combinational from state, registered op, flag and mem_ack; no strobe asserted outside its stated state.
REQ-030 instr_cnt SHALL increment by 1 on each cycle with pc_write=1 (including illegal), wrapping 0xFFFFFFFF -> 0.
REQ-031 Latency with mem_ack in first request cycle: branch 3, ALU 4, STORE 4, LOAD 5 cycles FETCH-entry to FETCH-re-entry.
REQ-032 mem_ack outside FETCH/MEM SHALL be ignored.

Reset
REQ-033 reset=1 at an edge SHALL force state=FETCH, op register=0, instr_cnt=0 next cycle, overriding any transition including mid-MEM or HALT.
REQ-034 While reset=1, all strobe outputs and halted SHALL be 0, pending memory request dropped.

Verification
REQ-035 ALU-imm 01000, mem_ack always 1 -> states 0,1,2,4,0; alu_src=1 in EXEC; reg_write & pc_write in WB; instr_cnt 0->1.
REQ-036 LOAD, mem_ack delayed 3 cycles in MEM -> mem_req=1, addr_sel=1 for 3 cycles; then WB with wb_sel=1; total 7 cycles.
REQ-037 BEQ flag=01 -> pc_src=1; BEQ flag=00 -> pc_src=0; JMP any flag -> pc_src=1; each pc_write exactly once.
REQ-038 Opcode 10101 -> illegal=1 one cycle in DECODE, pc_src=0, back to FETCH.
REQ-039 HALT 11111 -> halted=1 indefinitely despite mem_ack toggling; reset -> FETCH, instr_cnt=0.
REQ-040 reset asserted mid-MEM of STORE -> next cycle state=0, mem_we=0, no pc_write, instr_cnt=0.
